// File: rtl/cmd_issuer.sv
// Command FIFO feeding a controller: pops one command at a time, pulses syscall,
// then idles OP_WAIT or CAS_WAIT cycles before the next issue.
module cmd_issuer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned OP_WAIT  = 1,
  parameter int unsigned CAS_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] in_cmd,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [11:0] command,
  output logic        syscall,
  output logic [4:0]  count,
  output logic        empty,
  output logic        full
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = 5;
  localparam int unsigned WW   = 8;
  localparam int unsigned CMDW = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [CMDW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d, full_q, full_d, in_ready_q;
  logic [1:0]      state_q, state_d;
  logic [CMDW-1:0] cmd_q, cmd_d;
  logic [WW-1:0]   wcnt_q, wcnt_d, wload;
  logic            syscall_q, syscall_d;
  logic            push, pop;

  // A full FIFO refuses pushes even if the same edge pops.
  assign push = in_valid && !full_q && !flush;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_cmd;
  end

  // Issue sequencer; flush overrides whatever the state machine wanted.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wcnt_d  = wcnt_q;
    pop     = 1'b0;
    wload   = (cmd_q[11:9] == 3'b111) ? WW'(CAS_WAIT) : WW'(OP_WAIT);
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          state_d = S_ISSUE;
          cmd_d   = mem_q[rd_ptr_q];
          pop     = 1'b1;
        end
      end
      S_ISSUE: begin
        wcnt_d  = wload;
        state_d = (wload == '0) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q <= WW'(1)) begin
          wcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q - WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cmd_d   = cmd_q;
      wcnt_d  = '0;
      pop     = 1'b0;
    end
    syscall_d = (state_d == S_ISSUE);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      wcnt_q     <= '0;
      syscall_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wcnt_q     <= wcnt_d;
      syscall_q  <= syscall_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      in_ready_q <= !full_d;
    end
  end

  assign in_ready = in_ready_q;
  assign command  = cmd_q;
  assign syscall  = syscall_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;

endmodule

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter OP_WAIT, default 1, meaning idle cycles after a non-CAS issue.
REQ-003 SHALL have parameter CAS_WAIT, default 2, meaning idle cycles after a CAS (opcode 3'b111) issue.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port: in_cmd  input  12  command {opcode[11:9], addr1[8:6], addr2[5:3], addr3[2:0]}.
REQ-008 SHALL have port: in_valid  input  1  in_cmd valid.
REQ-009 SHALL have port: in_ready  output  1  FIFO can accept; equals !full.
REQ-010 SHALL have port: flush  input  1  synchronous discard of all queued commands.
REQ-011 SHALL have port: command  output  12  command presented to the controller, registered.
REQ-012 SHALL have port: syscall  output  1  one-cycle RUN pulse to the controller, registered.
REQ-013 SHALL have port: count  output  5  FIFO occupancy, 0..DEPTH.
REQ-014 SHALL have port: empty  output  1  count==0.
REQ-015 SHALL have port: full  output  1  count==DEPTH.

Function
REQ-016 SHALL accept a push on a rising edge when in_valid && in_ready && !flush.
REQ-017 SHALL drop an in_valid push while full with no state change; no overwrite.
REQ-018 SHALL store commands in order; read and write pointers wrap modulo DEPTH.
REQ-019 SHALL implement states IDLE, ISSUE, WAIT.
REQ-020 IDLE: when FIFO non-empty at an edge, SHALL go to ISSUE, load command from the head entry, pop it, and drive syscall=1 for the following cycle.
REQ-021 ISSUE (one cycle, syscall=1): SHALL load wait counter with OP_WAIT, or CAS_WAIT when command[11:9]==3'b111, then go to WAIT; if the loaded value is 0, SHALL go to IDLE instead.
REQ-022 WAIT: syscall=0; SHALL decrement the counter each cycle and go to IDLE on the edge where it reaches 0.
REQ-023 Issue spacing SHALL be 2+OP_WAIT cycles between syscall pulses for non-CAS and 2+CAS_WAIT for CAS when the FIFO stays non-empty; the IDLE cycle is included.
REQ-024 Latency SHALL be: push accepted at edge E0 into an empty, IDLE block gives syscall high in the cycle after edge E1.
REQ-025 command SHALL hold its value from issue until the next issue; it SHALL NOT change while syscall=1 or in WAIT.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; in_ready is based on full only, not the same-cycle pop.
REQ-027 flush SHALL, at the next edge, empty the FIFO (count=0), force IDLE, and drive syscall=0; command keeps its last value.
REQ-028 When flush and in_valid occur in the same cycle, flush SHALL take priority and the push SHALL be dropped.
REQ-029 When flush occurs in the cycle where ISSUE would start, no issue SHALL occur.
REQ-030 syscall SHALL never be high in two consecutive cycles.

Reset
REQ-031 rst high SHALL asynchronously force: state IDLE, pointers 0, count 0, empty 1, full 0, in_ready 1, syscall 0, command 12'h000, wait counter 0.
REQ-032 rst asserted mid-WAIT or mid-ISSUE SHALL abort the operation and lose all queued commands; the first issue after release SHALL occur no earlier than the cycle after the second edge following a new push.

Verification
REQ-033 Reset, push 12'h0C8 (op 000) at edge 1 -> syscall=1 and command=12'h0C8 in the cycle after edge 2; count returns to 0.
REQ-034 Push 3 non-CAS commands back-to-back, OP_WAIT=1 -> three syscall pulses spaced exactly 3 cycles, in push order.
REQ-035 Push CAS 12'hE53 then 12'h0C8, CAS_WAIT=2 -> pulses 4 cycles apart; command=12'hE53 stable throughout the CAS window.
REQ-036 Fill to 8 with issuer stalled behind a CAS -> full=1, in_ready=0; a 9th push is dropped; all 8 commands are issued in order; pointer wrap is exercised by pushing 8 more.
REQ-037 flush with count=5 together with in_valid -> count=0 next edge, no syscall, push dropped; a later push issues normally.
REQ-038 rst pulsed mid-WAIT with count=3 -> all outputs at reset values immediately, no syscall until a new push.
